// File: rtl/cnt_capture.sv
// rtl/cnt_capture.sv - input-capture timer measuring edge-to-edge intervals of an async signal
// Optional overrun protection enabled by defining CNT_CAPTURE_OVERRUN_EN.
module cnt_capture #(
    parameter int width       = 16,
    parameter int sync_stages = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic             clr_it_i,
    input  logic             sig_i,
    output logic [width-1:0] cap_o,
    output logic             valid_o,
    output logic             it_o,
    output logic             ovf_o,
    output logic             ovr_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    localparam logic [width-1:0] ONE  = {{(width-1){1'b0}}, 1'b1};
    localparam logic [width-1:0] ONES = {width{1'b1}};

    logic [sync_stages-1:0] sync_q;
    logic                   hist_q;
    state_t                 state_q, state_d;
    logic [1:0]             mode_q, mode_d;
    logic [width-1:0]       cnt_q, cnt_d;
    logic [width-1:0]       cap_q, cap_d;
    logic                   valid_q, valid_d;
    logic                   it_q, it_d;
    logic                   ovf_q, ovf_d;
`ifdef CNT_CAPTURE_OVERRUN_EN
    logic                   ovr_q, ovr_d;
`endif

    logic sig_sync;
    logic rise;
    logic fall;
    logic start_edge;
    logic stop_edge;
    logic period_mode;
    logic capture;
    logic timeout;

    assign sig_sync = sync_q[sync_stages-1];
    assign rise     = sig_sync & ~hist_q;
    assign fall     = ~sig_sync & hist_q;

    // Mode bit 0 picks the start polarity; width modes stop on the opposite edge.
    assign start_edge  = mode_q[0] ? fall : rise;
    assign stop_edge   = (mode_q[1] ^ mode_q[0]) ? fall : rise;
    assign period_mode = ~mode_q[1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q  <= '0;
            hist_q  <= 1'b0;
            state_q <= IDLE;
            mode_q  <= 2'b00;
            cnt_q   <= '0;
            cap_q   <= '0;
            valid_q <= 1'b0;
            it_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[sync_stages-2:0], sig_i};
            hist_q  <= sig_sync;
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            valid_q <= valid_d;
            it_q    <= it_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef CNT_CAPTURE_OVERRUN_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        timeout = 1'b0;

        if (!en_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                    mode_d  = mode_i;
                    cnt_d   = '0;
                end
                ARM: begin
                    cnt_d = '0;
                    if (start_edge) begin
                        state_d = MEAS;
                    end
                end
                MEAS: begin
                    if (stop_edge) begin
                        // In period modes the stop edge doubles as the next start edge.
                        capture = 1'b1;
                        cnt_d   = '0;
                        if (!period_mode) begin
                            state_d = ARM;
                        end
                    end else if (cnt_q == ONES) begin
                        timeout = 1'b1;
                        cnt_d   = '0;
                        state_d = ARM;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Clear is applied first so that a same-cycle set takes priority.
    always_comb begin
        cap_d   = cap_q;
        valid_d = valid_q;
        it_d    = it_q;
        ovf_d   = ovf_q;
`ifdef CNT_CAPTURE_OVERRUN_EN
        ovr_d   = ovr_q;
`endif

        if (!clr_it_i) begin
            valid_d = 1'b0;
            it_d    = 1'b0;
            ovf_d   = 1'b0;
`ifdef CNT_CAPTURE_OVERRUN_EN
            ovr_d   = 1'b0;
`endif
        end

        if (capture) begin
`ifdef CNT_CAPTURE_OVERRUN_EN
            if (valid_q) begin
                ovr_d = 1'b1;
            end else begin
                cap_d = cnt_q + ONE;
            end
`else
            cap_d = cnt_q + ONE;
`endif
            valid_d = 1'b1;
            it_d    = 1'b1;
        end

        if (timeout) begin
            ovf_d = 1'b1;
            it_d  = 1'b1;
        end
    end

    assign cap_o   = cap_q;
    assign valid_o = valid_q;
    assign it_o    = it_q;
    assign ovf_o   = ovf_q;
    assign busy_o  = (state_q == MEAS);
`ifdef CNT_CAPTURE_OVERRUN_EN
    assign ovr_o   = ovr_q;
`else
    assign ovr_o   = 1'b0;
`endif

endmodule

// File: doc/cnt_capture.md
# cnt_capture

Input-capture timer: measures intervals between edges of an asynchronous input `sig` in `clk` cycles and reports them through a capture register with an interrupt. It is the measuring counterpart of the `cnt` interval generator: `cnt` produces events at a programmed count, `cnt_capture` turns observed events back into a count. It sits beside `cnt`/`clkdiv` in timer subsystems, for period and pulse-width measurement of external signals.

## Interface
- `width`, 16: counter and capture width; legal range ≥ 4.
- `sync_stages`, 2: synchronizer flops on `sig`; legal range ≥ 2.

- `clk` input 1: clock.
- `rstn` input 1: reset, asynchronous, active-low.
- `en` input 1: enable. Low forces IDLE.
- `mode` input 2: edge-pair select, latched on IDLE→ARM.
  - 00: rise→rise (period).
  - 01: fall→fall (period).
  - 10: rise→fall (high width).
  - 11: fall→rise (low width).
- `clr_it` input 1: active-low level clear of `it`, `valid`, `ovf`, `ovr`.
- `sig` input 1: asynchronous measured signal.
- `cap` output width: last captured interval.
- `valid` output 1: sticky; a capture has occurred since the last clear.
- `it` output 1: sticky interrupt; set on capture or timeout.
- `ovf` output 1: sticky; measurement timed out.
- `ovr` output 1: sticky; capture while `valid` was still set (see Configuration).
- `busy` output 1: FSM in MEAS.

## Operation
- Synchronizer: `sig` passes through `sync_stages` flops, then one history flop. Rise = sync & ~hist; fall = ~sync & hist. Edges are acted on only in ARM and MEAS.
- FSM states IDLE, ARM, MEAS:
  - IDLE: `cnt` = 0. `en`=1 → ARM and latch `mode`.
  - ARM: start edge → MEAS with `cnt` = 0.
  - MEAS, each cycle:
    - Stop edge: `cap` = `cnt`+1, set `valid` and `it`.
      - Period modes: `cnt` = 0 and stay in MEAS; the stop edge is also the next start edge.
      - Width modes: → ARM.
    - Else if `cnt` == all-ones: set `ovf` and `it`, leave `cap` unchanged, → ARM.
    - Else: `cnt` = `cnt`+1.
- Interval arithmetic: start and stop edges detected N cycles apart give `cap` = N. Legal range is 1 … 2^width−1. A timeout occurs when no stop edge has arrived by N = 2^width, i.e. while `cnt` holds 2^width−1 and a further cycle elapses without a stop edge.
- `en`=0 in any state → IDLE next cycle; the measurement in progress is discarded; `cap` and the sticky flags are retained.
- `clr_it`=0 clears `it`, `valid`, `ovf`, `ovr` synchronously. When a set and a clear fall in the same cycle, the set wins.
- Changing `mode` while `en`=1 has no effect until the next IDLE→ARM.

## Timing
- Reset values: `cap`=0, `valid`=0, `it`=0, `ovf`=0, `ovr`=0, `busy`=0; FSM=IDLE; synchronizer and history flops = 0.
- `sig` transition first sampled at edge k → edge detected during cycle k+`sync_stages`−1 → `cap`/`valid`/`it` updated at edge k+`sync_stages`.
- Both edges of a pair see identical latency, so `cap` is exact to ±1 clk of sampling uncertainty.
- Minimum resolvable pulse: 1 clk high or low after synchronization. Shorter pulses may be lost.
- `en` rising at edge k: ARM from edge k+1. Edges detected in the cycle `en` rises are ignored.
- `busy` asserts at the edge that enters MEAS and drops at the edge that leaves it.

## Configuration
- `CNT_CAPTURE_OVERRUN_EN` defined: a capture while `valid`=1 sets `ovr` and does not update `cap`, which holds the first unread value; `it` stays set.
- Not defined: `ovr` is tied 0 and every capture overwrites `cap`.

## Test plan
- Period: width=8, mode=00, `sig` square wave with period 10 clk, en=1 → `cap`=10 on each rising edge; `valid`=1, `it`=1, `busy` held at 1.
- Widths: mode=10, high pulse of 3 clk → `cap`=3, then ARM. mode=11, low pulse of 7 clk → `cap`=7.
- Timeout: width=8, mode=00, one rising edge then `sig` constant → 256 cycles after start detection, `ovf`=1, `it`=1, `cap` unchanged, FSM in ARM.
- Clear: `clr_it`=0 for 1 cycle → `it`, `valid`, `ovf` = 0. `clr_it`=0 in the same cycle as a capture → `it`=1, `valid`=1.
- Overrun: captures 5 then 9 with no clear.
  - Macro defined: `cap`=5, `ovr`=1.
  - Macro undefined: `cap`=9, `ovr`=0.
- Abort: `rstn`=0 mid-MEAS → all outputs 0 immediately. `en`=0 mid-MEAS → IDLE next cycle, `busy`=0, previous `cap` retained, no `it`.
